// File: rtl/resp_cap_pkg.sv
// Shared types, default constants and the MISR step function for the
// response-capture stage. Used by the RTL and by the reference model.
package resp_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cap_state_e;

  localparam int unsigned MISR_MAX_W  = 64;
  localparam logic [15:0] DEF_POLY    = 16'h1021;
  localparam logic [15:0] DEF_SEED    = 16'hFFFF;

  // Generic MISR step at the widest supported width; sig_w selects the
  // live signature width, bits above it come back as zero.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] resp,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           sig_w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] fb;
    mask = (MISR_MAX_W'(1) << sig_w) - MISR_MAX_W'(1);
    fb   = '0;
    if (((sig >> (sig_w - 1)) & MISR_MAX_W'(1)) != '0) begin
      fb = poly;
    end
    return ((sig << 1) ^ fb ^ resp) & mask;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Signature register: reloads SEED on load, folds one response vector per
// enabled cycle. Load wins over enable.
module misr_reg
  import resp_cap_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter int               OUT_W = 8,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [OUT_W-1:0] resp,
  output logic [SIG_W-1:0] sig
);

  if (SIG_W < OUT_W) begin : g_bad_w
    $error("misr_reg: SIG_W must be >= OUT_W");
  end
  if (SIG_W > int'(MISR_MAX_W)) begin : g_bad_max
    $error("misr_reg: SIG_W exceeds MISR_MAX_W");
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= SIG_W'(misr_step(MISR_MAX_W'(sig), MISR_MAX_W'(resp),
                              MISR_MAX_W'(POLY), SIG_W));
    end
  end

endmodule

// File: rtl/resp_misr_capture.sv
// Response-capture stage: compacts num_vectors netlist output vectors into a
// MISR signature and compares it with a golden value when the run completes.
module resp_misr_capture
  import resp_cap_pkg::*;
#(
  parameter int               OUT_W = 8,
  parameter int               SIG_W = 16,
  parameter int               CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic             in_valid,
  input  logic [OUT_W-1:0] in_resp,
  output logic             in_ready,
  output logic [SIG_W-1:0] sig_out,
  output logic [CNT_W-1:0] vec_count,
  output logic             busy,
  output logic             done,
  output logic             match,
  output cap_state_e       state_dbg
);

  // Handshake: a vector transfers on the rising edge where in_valid and
  // in_ready are both high; in_ready is high exactly while in RUN, so the
  // source may hold in_valid and in_resp until in_ready is seen.

  cap_state_e       state;
  logic [CNT_W-1:0] target;
  logic             start_ok;
  logic             xfer;

  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
  assign xfer      = in_valid && in_ready;
  assign match     = done && (sig_out == golden_sig);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec_count <= '0;
      target    <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec_count <= '0;
            target    <= num_vectors;
            if (num_vectors == '0) begin
              state    <= ST_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= ST_RUN;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            vec_count <= vec_count + CNT_W'(1);
            // Last vector: leave RUN on the same edge that accepts it.
            if ((vec_count + CNT_W'(1)) == target) begin
              state    <= ST_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  misr_reg #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .en    (xfer),
    .resp  (in_resp),
    .sig   (sig_out)
  );

endmodule

// File: tb/tb_resp_misr_capture.sv
// Bench for resp_misr_capture: directed and randomized runs checked against a
// queue-based model that refolds all accepted vectors from SEED.
module tb_resp_misr_capture;
  import resp_cap_pkg::*;

  localparam int          OUT_W = 8;
  localparam int          SIG_W = 16;
  localparam int          CNT_W = 16;
  localparam logic [15:0] POLY  = 16'h1021;
  localparam logic [15:0] SEED  = 16'hFFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic [SIG_W-1:0] golden_sig = '0;
  logic             in_valid = 1'b0;
  logic [OUT_W-1:0] in_resp = '0;
  logic             in_ready;
  logic [SIG_W-1:0] sig_out;
  logic [CNT_W-1:0] vec_count;
  logic             busy;
  logic             done;
  logic             match;
  cap_state_e       state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: vectors accepted in the current run, target, and run status.
  logic [OUT_W-1:0] exp_q[$];
  int               m_target = 0;
  bit               m_run = 1'b0;
  bit               m_done = 1'b0;
  logic             ready_seen;

  always #5 clk = ~clk;

  resp_misr_capture #(
    .OUT_W (OUT_W),
    .SIG_W (SIG_W),
    .CNT_W (CNT_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_vectors (num_vectors),
    .golden_sig  (golden_sig),
    .in_valid    (in_valid),
    .in_resp     (in_resp),
    .in_ready    (in_ready),
    .sig_out     (sig_out),
    .vec_count   (vec_count),
    .busy        (busy),
    .done        (done),
    .match       (match),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SIG_W-1:0] ref_sig();
    logic [63:0] s;
    s = 64'(SEED);
    foreach (exp_q[i]) s = misr_step(s, 64'(exp_q[i]), 64'(POLY), SIG_W);
    return s[SIG_W-1:0];
  endfunction

  // One clock with the given inputs; the model advances, then all outputs
  // are compared #1 after the edge.
  task automatic cycle(input logic s, input logic [CNT_W-1:0] nv, input logic v,
                       input logic [OUT_W-1:0] r, input logic rn);
    logic [SIG_W-1:0] es;
    cap_state_e       est;
    start = s; num_vectors = nv; in_valid = v; in_resp = r; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      exp_q.delete(); m_target = 0; m_run = 0; m_done = 0;
    end else if (!m_run && s) begin
      exp_q.delete(); m_target = int'(nv); m_run = (nv != 0); m_done = (nv == 0);
    end else if (m_run && v) begin
      exp_q.push_back(r);
      if (exp_q.size() == m_target) begin m_run = 0; m_done = 1; end
    end
    #1;
    es  = ref_sig();
    est = m_run ? ST_RUN : (m_done ? ST_DONE : ST_IDLE);
    check("sig_out",   64'(sig_out),   64'(es));
    check("vec_count", 64'(vec_count), 64'(exp_q.size()));
    check("busy",      64'(busy),      64'(m_run));
    check("in_ready",  64'(in_ready),  64'(m_run));
    check("done",      64'(done),      64'(m_done));
    check("match",     64'(match),     64'(m_done && es == golden_sig));
    check("state",     64'(state_dbg), 64'(est));
    if (in_ready) ready_seen = 1'b1;
    start = 0; in_valid = 0; rst_n = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, OUT_W'($urandom), 1'b1);
  endtask

  initial begin
    // Reset state
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 8'h5A, 1'b0);
    check("rst_sig", 64'(sig_out), 64'(16'hFFFF));

    // One zero vector; in_valid alongside start must be ignored
    cycle(1'b1, 16'd1, 1'b1, 8'h33, 1'b1);
    cycle(1'b0, '0, 1'b1, 8'h00, 1'b1);
    check("sig_00", 64'(sig_out), 64'(16'hEFDF));
    check("cnt_00", 64'(vec_count), 64'd1);
    check("done_00", 64'(done), 64'd1);

    // 8'hA5 with matching and non-matching golden values
    golden_sig = 16'hEF7A;
    cycle(1'b1, 16'd1, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1, 8'hA5, 1'b1);
    check("sig_a5", 64'(sig_out), 64'(16'hEF7A));
    check("match_a5", 64'(match), 64'd1);
    golden_sig = 16'h0000;
    idle(1);
    check("nomatch_a5", 64'(match), 64'd0);

    // Zero-length run: straight to DONE, in_ready never raised
    ready_seen = 1'b0;
    cycle(1'b1, 16'd0, 1'b0, '0, 1'b1);
    check("z_sig", 64'(sig_out), 64'(16'hFFFF));
    check("z_cnt", 64'(vec_count), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, OUT_W'($urandom), 1'b1);
    check("z_ready", 64'(ready_seen), 64'd0);

    // Four vectors with stalls, then extra valids after DONE
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      cycle(1'b1, 16'd4, 1'b0, '0, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, '0, pat[i], OUT_W'($urandom), 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, OUT_W'($urandom), 1'b1);
      check("p4_cnt", 64'(vec_count), 64'd4);
    end

    // Reset after 2 of 5 vectors, then a fresh run
    cycle(1'b1, 16'd5, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1, 8'h12, 1'b1);
    cycle(1'b0, '0, 1'b1, 8'h34, 1'b1);
    cycle(1'b0, '0, 1'b1, 8'h56, 1'b0);
    check("mr_sig", 64'(sig_out), 64'(16'hFFFF));
    check("mr_busy", 64'(busy), 64'd0);
    cycle(1'b1, 16'd3, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, OUT_W'($urandom), 1'b1);
    check("mr_cnt", 64'(vec_count), 64'd3);

    // start during RUN with a different count is ignored
    cycle(1'b1, 16'd3, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1, OUT_W'($urandom), 1'b1);
    cycle(1'b1, 16'd9, 1'b1, OUT_W'($urandom), 1'b1);
    cycle(1'b1, 16'd1, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1, OUT_W'($urandom), 1'b1);
    check("sr_cnt", 64'(vec_count), 64'd3);
    check("sr_done", 64'(done), 64'd1);

    // Randomized runs: random lengths, stalls, stray starts and resets
    for (int run = 0; run < 25; run++) begin
      logic [CNT_W-1:0] nv;
      nv = CNT_W'($urandom_range(0, 20));
      golden_sig = ($urandom_range(0, 1) == 1) ? 16'hEF7A : SIG_W'($urandom);
      cycle(1'b1, nv, 1'($urandom), OUT_W'($urandom), 1'b1);
      for (int i = 0; i < 40; i++) begin
        cycle(($urandom_range(0, 15) == 0), CNT_W'($urandom_range(0, 20)),
              ($urandom_range(0, 3) != 0), OUT_W'($urandom),
              ($urandom_range(0, 99) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
